// File: rtl/ub_port_arbiter.sv
// Round-robin arbiter sharing the single-port Unified Buffer SRAM between the host/DMA path (r0)
// and the systolic-array path (r1); read data returns to its issuer one cycle after acceptance.
module ub_port_arbiter #(
  parameter int unsigned ADDRESSSIZE = 15,
  parameter int unsigned WORDSIZE    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   r0_req_valid,
  output logic                   r0_req_ready,
  input  logic                   r0_req_we,
  input  logic [ADDRESSSIZE-1:0] r0_req_addr,
  input  logic [WORDSIZE-1:0]    r0_req_wdata,
  output logic                   r0_rsp_valid,
  output logic [WORDSIZE-1:0]    r0_rsp_data,
  input  logic                   r1_req_valid,
  output logic                   r1_req_ready,
  input  logic                   r1_req_we,
  input  logic [ADDRESSSIZE-1:0] r1_req_addr,
  input  logic [WORDSIZE-1:0]    r1_req_wdata,
  output logic                   r1_rsp_valid,
  output logic [WORDSIZE-1:0]    r1_rsp_data,
  output logic                   sram_write_enable,
  output logic [ADDRESSSIZE-1:0] sram_address,
  output logic [WORDSIZE-1:0]    sram_data_in,
  input  logic [WORDSIZE-1:0]    sram_data_out
);

  logic       prio_q, prio_d;
  logic [1:0] rsp_pend_q, rsp_pend_d;
  logic       gnt0, gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (r0_req_valid && r1_req_valid) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = r0_req_valid;
        gnt1 = r1_req_valid;
      end
    end
  end

  assign r0_req_ready = gnt0;
  assign r1_req_ready = gnt1;

  // With no grant the SRAM sees an all-zero read; its data is never forwarded.
  always_comb begin
    sram_write_enable = 1'b0;
    sram_address      = '0;
    sram_data_in      = '0;
    if (gnt0) begin
      sram_write_enable = r0_req_we;
      sram_address      = r0_req_addr;
      sram_data_in      = r0_req_wdata;
    end else if (gnt1) begin
      sram_write_enable = r1_req_we;
      sram_address      = r1_req_addr;
      sram_data_in      = r1_req_wdata;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
    rsp_pend_d = {gnt1 & ~r1_req_we, gnt0 & ~r0_req_we};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= 1'b0;
      rsp_pend_q <= 2'b00;
    end else begin
      prio_q     <= prio_d;
      rsp_pend_q <= rsp_pend_d;
    end
  end

  assign r0_rsp_valid = rsp_pend_q[0];
  assign r1_rsp_valid = rsp_pend_q[1];
  assign r0_rsp_data  = rsp_pend_q[0] ? sram_data_out : '0;
  assign r1_rsp_data  = rsp_pend_q[1] ? sram_data_out : '0;

endmodule

// File: tb/tb_ub_port_arbiter.sv
// Directed bench for ub_port_arbiter with a behavioural SRAM, a grant/priority reference model
// and a response scoreboard.
module tb_ub_port_arbiter;
  localparam int AW = 15;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_req_valid = 1'b0, r0_req_we = 1'b0;
  logic [AW-1:0] r0_req_addr = '0;
  logic [DW-1:0] r0_req_wdata = '0;
  logic          r1_req_valid = 1'b0, r1_req_we = 1'b0;
  logic [AW-1:0] r1_req_addr = '0;
  logic [DW-1:0] r1_req_wdata = '0;
  logic          r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid;
  logic [DW-1:0] r0_rsp_data, r1_rsp_data;
  logic          sram_write_enable;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_data_in, sram_data_out;

  ub_port_arbiter #(.ADDRESSSIZE(AW), .WORDSIZE(DW)) dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_we(r0_req_we),
    .r0_req_addr(r0_req_addr), .r0_req_wdata(r0_req_wdata),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_data(r0_rsp_data),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_we(r1_req_we),
    .r1_req_addr(r1_req_addr), .r1_req_wdata(r1_req_wdata),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_data(r1_rsp_data),
    .sram_write_enable(sram_write_enable), .sram_address(sram_address),
    .sram_data_in(sram_data_in), .sram_data_out(sram_data_out)
  );

  always #5 clk = ~clk;

  // Single-port SRAM: registered read, data_out held during a write cycle.
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] sram_q;
  always @(posedge clk) begin
    if (sram_write_enable) mem[sram_address] <= sram_data_in;
    else sram_q <= mem[sram_address];
  end
  assign sram_data_out = sram_q;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          sb[$];
  logic [DW-1:0] ref_mem [int];
  bit            exp_prio = 1'b0;
  logic          g0, g1;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check grant/SRAM drive before the edge, update model at the edge,
  // then check responses just after it.
  task automatic cycle();
    logic e0, e1, ew, v0e, v1e;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, x0, x1;
    rsp_t it;
    @(negedge clk);
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst) begin
      if (r0_req_valid && r1_req_valid) begin
        e0 = ~exp_prio;
        e1 = exp_prio;
      end else begin
        e0 = r0_req_valid;
        e1 = r1_req_valid;
      end
    end
    ew = e0 ? r0_req_we : (e1 ? r1_req_we : 1'b0);
    ea = e0 ? r0_req_addr : (e1 ? r1_req_addr : '0);
    ed = e0 ? r0_req_wdata : (e1 ? r1_req_wdata : '0);
    chk("r0_ready", 64'(r0_req_ready), 64'(e0));
    chk("r1_ready", 64'(r1_req_ready), 64'(e1));
    chk("sram_we", 64'(sram_write_enable), 64'(ew));
    chk("sram_addr", 64'(sram_address), 64'(ea));
    chk("sram_din", sram_data_in, ed);
    g0 = r0_req_ready;
    g1 = r1_req_ready;
    @(posedge clk);
    if (rst) begin
      exp_prio = 1'b0;
      sb.delete();
    end else if (e0 || e1) begin
      exp_prio = e0;
      if (ew) begin
        ref_mem[int'(ea)] = ed;
      end else begin
        it.port = e1;
        it.data = ref_mem.exists(int'(ea)) ? ref_mem[int'(ea)] : 'x;
        sb.push_back(it);
      end
    end
    #1;
    v0e = 1'b0; v1e = 1'b0; x0 = '0; x1 = '0;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      if (it.port) begin v1e = 1'b1; x1 = it.data; end
      else begin v0e = 1'b1; x0 = it.data; end
    end
    chk("r0_rsp_valid", 64'(r0_rsp_valid), 64'(v0e));
    chk("r1_rsp_valid", 64'(r1_rsp_valid), 64'(v1e));
    chk("r0_rsp_data", r0_rsp_data, x0);
    chk("r1_rsp_data", r1_rsp_data, x1);
  endtask

  task automatic drv0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r0_req_valid = v; r0_req_we = we; r0_req_addr = a; r0_req_wdata = d;
  endtask

  task automatic drv1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r1_req_valid = v; r1_req_we = we; r1_req_addr = a; r1_req_wdata = d;
  endtask

  initial begin
    // Reset held, then idle after release.
    repeat (3) cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // Preload through r0.
    drv0(1, 1, 15'h0001, 64'hA);    cycle();
    drv0(1, 1, 15'h0002, 64'hB);    cycle();
    drv0(1, 1, 15'h0005, 64'hCAFE); cycle();

    // r0 write then r1 read-after-write of the same address.
    drv0(1, 1, 15'h0010, 64'h1122334455667788); cycle();
    drv0(0, 0, '0, '0);
    drv1(1, 0, 15'h0010, '0); cycle();
    drv1(0, 0, '0, '0); cycle();
    chk("raw_r1_data", r1_rsp_data, '0);

    // Continuous contention: strict alternation starting with r0.
    drv0(1, 0, 15'h0001, '0);
    drv1(1, 0, 15'h0002, '0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk($sformatf("cont_grant%0d", i), 64'({g1, g0}), (i % 2 == 1) ? 64'd2 : 64'd1);
    end
    drv0(0, 0, '0, '0); drv1(0, 0, '0, '0);
    cycle();

    // r1 alone three times, then first conflict goes to r0.
    drv1(1, 0, 15'h0002, '0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("r1_alone%0d", i), 64'({g1, g0}), 64'd2);
    end
    drv0(1, 0, 15'h0001, '0);
    cycle();
    chk("first_conflict", 64'({g1, g0}), 64'd1);
    drv0(0, 0, '0, '0); drv1(0, 0, '0, '0);
    cycle();

    // r0 read followed by an r1 write; response must be unaffected.
    drv0(1, 0, 15'h0005, '0); cycle();
    drv0(0, 0, '0, '0);
    drv1(1, 1, 15'h0006, 64'hBEEF);
    chk("read_then_write", r0_rsp_data, 64'hCAFE);
    cycle();
    drv1(0, 0, '0, '0);
    drv0(1, 0, 15'h0006, '0); cycle();
    chk("write_landed", r0_rsp_data, 64'hBEEF);
    drv0(0, 0, '0, '0); cycle();

    // Read accepted, then reset in the following cycle.
    drv0(1, 0, 15'h0001, '0); cycle();
    drv0(0, 0, '0, '0);
    rst = 1'b1;
    #1;
    chk("rst_kills_rsp", 64'(r0_rsp_valid), 64'd0);
    chk("rst_ready0", 64'(r0_req_ready), 64'd0);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    chk("no_rsp_after_rst", 64'(r0_rsp_valid), 64'd0);
    drv0(1, 0, 15'h0001, '0);
    drv1(1, 0, 15'h0002, '0);
    cycle();
    chk("post_rst_grant", 64'({g1, g0}), 64'd1);
    drv0(0, 0, '0, '0); drv1(0, 0, '0, '0);
    repeat (2) cycle();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ub_port_arbiter.md
Name: ub_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single-port Unified Buffer SRAM (1-cycle registered read; a write cycle does not update the read data) between two masters.
- Requester 0: host/DMA load path. Requester 1: systolic-array operand fetch / result writeback path.
- Accepts one read or write per cycle over valid/ready handshakes and drives the SRAM port.
- Returns read data to the requester that issued the read, exactly one cycle after acceptance.

Parameters:
- ADDRESSSIZE, 15, SRAM address width in bits.
- WORDSIZE, 64, SRAM data word width in bits (8 bytes).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- r0_req_valid  input  1  requester 0 has a request.
- r0_req_ready  output  1  requester 0 request accepted this cycle.
- r0_req_we  input  1  1 = write, 0 = read.
- r0_req_addr  input  ADDRESSSIZE  request address.
- r0_req_wdata  input  WORDSIZE  write data.
- r0_rsp_valid  output  1  read data for requester 0 is valid.
- r0_rsp_data  output  WORDSIZE  read data.
- r1_req_valid, r1_req_ready, r1_req_we, r1_req_addr, r1_req_wdata, r1_rsp_valid, r1_rsp_data: same as the r0_* ports, for requester 1.
- sram_write_enable  output  1  to SRAM write_enable.
- sram_address  output  ADDRESSSIZE  to SRAM address.
- sram_data_in  output  WORDSIZE  to SRAM data_in.
- sram_data_out  input  WORDSIZE  from SRAM data_out.

Behaviour:
- State:
  - prio: 1 bit, the requester favoured on conflict; reset 0.
  - rsp_pend: 2 bits, one-hot owner of the read issued last cycle; reset 00.
- Grant (combinational):
  - Only one requester valid → it is granted.
  - Both valid → requester prio is granted.
  - Neither valid → no grant.
  - rN_req_ready = grant to N. Ready depends on valid; a requester must not drive valid from its own ready.
  - The transfer occurs on the rising edge where valid && ready.
- prio update at each edge with a grant: prio <= index of the non-granted requester. Unchanged when there is no grant. Result: strict alternation under contention, no starvation.
- SRAM drive (combinational, same cycle as grant):
  - sram_address = granted addr.
  - sram_data_in = granted wdata.
  - sram_write_enable = granted we.
- SRAM drive with no grant: write_enable=0, address=0, data_in=0. The SRAM performs a dummy read; harmless, because a response is valid for one cycle only.
- Read latency is exactly 1. Accepting a read of requester N at edge k gives:
  - rsp_pend[N]=1 during cycle k+1;
  - rN_rsp_valid=1 during that cycle;
  - rN_rsp_data = sram_data_out.
- rsp_valid is a single-cycle pulse. There is no response backpressure; requesters must sink the data. Back-to-back reads give back-to-back pulses.
- rsp_data for the non-owning requester, and for any requester when its rsp_valid=0, is driven to 0.
- Writes produce no response. A write accepted right after a read does not disturb that read's response: the SRAM holds data_out during a write cycle.
- Read-after-write to the same address in consecutive cycles returns the new data (the SRAM write has completed at the earlier edge).
- While rst=1:
  - readies = 0, sram_write_enable = 0, address/data_in = 0;
  - prio = 0, rsp_pend = 00, all rsp_valid = 0.
- Reset asserted mid-operation discards any pending response. No response pulse follows reset deassertion.
- Requester obligation: hold we/addr/wdata stable while valid && !ready. The arbiter does not register the payload.

Test Plan:
- Reset then idle → readies 0, rsp_valid 0, sram_write_enable 0 on every cycle; after release, still no rsp_valid with no requests.
- r0 writes 0x1122334455667788 to addr 0x0010, then r1 reads addr 0x0010 next cycle → r1_rsp_valid one cycle after its acceptance with data 0x1122334455667788; r0_rsp_valid stays 0.
- Both valid continuously for 6 cycles (reads, r0 addr 0x0001, r1 addr 0x0002, preloaded 0xA and 0xB) → grant order r0,r1,r0,r1,r0,r1; responses alternate 0xA, 0xB, each exactly one cycle after the grant.
- r1 alone valid for 3 cycles, then both valid → r1 granted 3 times; first conflict goes to r0 (prio=0).
- r0 read addr 0x0005 (preloaded 0xCAFE), then an r1 write to addr 0x0006 at the next edge → r0_rsp_data=0xCAFE in the cycle after the read; the write lands (verified by a later read of 0x0006).
- r0 read accepted, rst pulsed high in the following cycle → r0_rsp_valid 0 during and after reset; prio returns to 0 (both valid afterwards → r0 granted first).
